adda_sync_fifo: RTL

Parametrised single-clock FIFO for the ADC/DAC sample path. It is the successor to the team's fixed 14-bit sample FIFO and sits between the sample-rate front end and downstream DSP/DAC logic. Over that FIFO it adds:
- all DEPTH entries usable, with a full-width level counter;
- programmable almost-full and almost-empty thresholds;
- write and read protection with sticky overflow/underflow flags;
- synchronous flush;
- a read-valid strobe;
- an optional first-word-fall-through read mode.

---
 rtl/adda_sync_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/adda_sync_fifo.sv
// Single-clock sample FIFO for the ADC/DAC path: full-depth level counter, programmable
// thresholds, sticky error flags and flush. Define FIFO_FWFT_EN for first-word-fall-through reads.
module adda_sync_fifo #(
   parameter int DATA_WIDTH    = 14,
   parameter int DEPTH         = 64,
   parameter int AFULL_THRESH  = DEPTH - 5,
   parameter int AEMPTY_THRESH = 4,
   localparam int AW           = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [AW:0]           level,
   output logic                  full,
   output logic                  almost_full,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  above_half,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);
   localparam logic [AW:0] HALF_LVL   = (AW+1)'(DEPTH / 2);
   localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_THRESH);
   localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  wr_rej;
   logic                  rd_rej;

   // Flags are pure decodes of the registered level, so they change only at clock edges.
   assign full         = (level == FULL_LVL);
   assign empty        = (level == '0);
   assign almost_full  = (level >= AFULL_LVL);
   assign almost_empty = (level <= AEMPTY_LVL);
   assign above_half   = (level > HALF_LVL);

   // A flush suppresses both ports and any error reporting for its cycle.
   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      rd_acc = 1'b0;
      wr_acc = 1'b0;
      wr_rej = 1'b0;
      rd_rej = 1'b0;
      if (!clr) begin
         rd_acc = rd_en & ~empty;
         wr_acc = wr_en & (~full | rd_acc);
         wr_rej = wr_en & ~wr_acc;
         rd_rej = rd_en & empty;
      end
   end

   // NOTE: the sample array has no reset; the pointers and level alone define its contents.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   // Sticky error flags: a new error in the err_clr cycle wins; flush leaves them alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wr_rej | (overflow & ~err_clr);
         underflow <= rd_rej | (underflow & ~err_clr);
      end
   end

`ifdef FIFO_FWFT_EN
   // Head word is presented directly; forced to zero while empty so reset/flush read back zero.
   assign rd_valid = ~empty;
   assign rd_data  = empty ? '0 : mem[rd_ptr];
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if (clr) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) rd_data <= mem[rd_ptr];
      end
   end
`endif

endmodule
